mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter SZ, default 4096: byte size of the attached RAM_block.
REQ-002 Parameter MAX_WAIT, default 3: consecutive lost arbitrations after which the instruction port wins.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1: reset, asynchronous and active-low.
REQ-005 Port i_req_valid  in  1: instruction-fetch request valid.
REQ-006 Port i_req_ready  out  1: instruction request accepted this cycle.
REQ-007 Port i_req_addr  in  32: instruction fetch byte address.
REQ-008 Port i_rsp_valid / i_rsp_ready  out/in  1: instruction response handshake.
REQ-009 Port i_rsp_data  out  32: fetched word. Port i_rsp_err  out  1: access error.
REQ-010 Port d_req_valid / d_req_ready  in/out  1: data request handshake.
REQ-011 Port d_req_we  in  1: 1 = store, 0 = load.
REQ-012 Port d_req_addr  in  32: data byte address. Port d_req_wdata  in  32: store data.
REQ-013 Port d_rsp_valid / d_rsp_ready  out/in  1: data response handshake.
REQ-014 Port d_rsp_data  out  32: load data. Port d_rsp_err  out  1: access error.
REQ-015 Port mem_w_en  out  1: RAM write enable.
REQ-016 Port mem_addr  out  32: RAM address. Port mem_data_in  out  32: RAM write data.
REQ-017 Port mem_data_out  in  32: RAM combinational read data.

Function
REQ-018 A requester X SHALL be eligible when X_req_valid=1 and (X_rsp_valid=0 or X_rsp_ready=1).
REQ-019 At most one grant per cycle; grant is combinational and signalled by X_req_ready=1 in the same cycle. Ready=0 for non-eligible requesters.
REQ-020 Priority: data over instruction, except instruction wins when starve=MAX_WAIT.
REQ-021 Starve counter: +1 (saturating at MAX_WAIT) when instruction is eligible and not granted; cleared when instruction is granted or i_req_valid=0.
REQ-022 Error condition: addr[1:0]!=0 or addr>SZ-4 (unsigned).
REQ-023 Grant cycle: mem_addr=granted addr. mem_w_en=1 only for a data grant with we=1 and no error. mem_data_in=d_req_wdata on a data grant.
REQ-024 No-grant cycle: mem_addr=0, mem_w_en=0, mem_data_in=0.
REQ-025 Latency: the response is registered and appears exactly one cycle after the grant (X_rsp_valid=1 at cycle N+1).
REQ-026 Response data for a successful load/fetch = mem_data_out sampled at the grant edge. Data is 0 for stores and for errors.
REQ-027 err=1 only for error-condition requests; an erroneous request SHALL never write memory.
REQ-028 A response SHALL hold data/err stable while valid=1 and ready=0.
REQ-029 Response valid clears on ready=1 unless replaced by a new response from a same-cycle grant, in which case it stays valid=1 with the new data.
REQ-030 A data store at cycle N followed by a load of the same address at N+1 SHALL return the stored value.

Reset
REQ-031 On rst_n=0, immediately: i/d_rsp_valid=0, i/d_rsp_data=0, i/d_rsp_err=0, starve=0, all req_ready=0, mem_w_en=0, mem_addr=0, mem_data_in=0.
REQ-032 Reset asserted mid-grant SHALL suppress that write (mem_w_en low before the edge); no response is produced.
REQ-033 Arbitration resumes on the first rising edge after rst_n rises.

Verification
REQ-034 Single fetch: i_req addr=0, RAM[0..3]=0x01000093 -> i_req_ready=1 same cycle, i_rsp_valid=1 next cycle, data=0x01000093, err=0.
REQ-035 Store/load back-to-back: store 0x0000007B @16 then load @16 -> mem_w_en pulse 1 cycle, d_rsp_data=0x0000007B, err=0.
REQ-036 Contention: both valid continuously, MAX_WAIT=3 -> d granted 3 cycles, i granted on the 4th, then the counter clears.
REQ-037 Errors: load @0x2 and load @4094 -> d_rsp_err=1, data=0, mem_w_en never asserted. Store @4093 -> err=1, RAM unchanged.
REQ-038 Backpressure: d_rsp_ready=0 for 5 cycles with d_req_valid=1 -> d_req_ready=0, response stable. The instruction port keeps being served.
REQ-039 Reset mid-store: rst_n low during the grant cycle -> RAM word unchanged, all rsp_valid=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port RAM with
// combinational read data. Data wins by default; a starvation counter hands the port
// to instruction fetch after MAX_WAIT consecutive losses.

module mem_arbiter_rsp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_gnt,
    input  logic        i_load_ok,
    input  logic        i_err,
    input  logic [31:0] i_rdata,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_err
);
    // A grant in the same cycle as the handshake replaces the response in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= 32'h0;
            o_err   <= 1'b0;
        end else if (i_gnt) begin
            o_valid <= 1'b1;
            o_data  <= i_load_ok ? i_rdata : 32'h0;
            o_err   <= i_err;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

module mem_arbiter #(
    parameter int SZ       = 4096,
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        i_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] i_rsp_data,
    output logic        i_rsp_err,

    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,

    output logic        mem_w_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);
    localparam int              SW         = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(MAX_WAIT);
    localparam logic [31:0]     LAST_WORD  = 32'(SZ - 4);

    logic [SW-1:0] r_starve;
    logic          w_i_elig, w_d_elig;
    logic          w_i_force;
    logic          w_i_gnt, w_d_gnt;
    logic          w_i_err, w_d_err;

    // rst_n gates eligibility so every grant-derived output drops as soon as reset asserts.
    assign w_i_elig  = rst_n & i_req_valid & (~i_rsp_valid | i_rsp_ready);
    assign w_d_elig  = rst_n & d_req_valid & (~d_rsp_valid | d_rsp_ready);
    assign w_i_force = w_i_elig & (r_starve == STARVE_MAX);
    assign w_d_gnt   = w_d_elig & ~w_i_force;
    assign w_i_gnt   = w_i_elig & ~w_d_gnt;

    assign w_i_err = (|i_req_addr[1:0]) | (i_req_addr > LAST_WORD);
    assign w_d_err = (|d_req_addr[1:0]) | (d_req_addr > LAST_WORD);

    assign i_req_ready = w_i_gnt;
    assign d_req_ready = w_d_gnt;

    always_comb begin
        mem_w_en    = 1'b0;
        mem_addr    = 32'h0;
        mem_data_in = 32'h0;
        if (w_d_gnt) begin
            mem_addr    = d_req_addr;
            mem_data_in = d_req_wdata;
            mem_w_en    = d_req_we & ~w_d_err;
        end else if (w_i_gnt) begin
            mem_addr = i_req_addr;
        end
    end

    // Counts only losses while fetch is actually eligible; a stalled response holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (!i_req_valid || w_i_gnt) begin
            r_starve <= '0;
        end else if (w_i_elig && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    mem_arbiter_rsp u_i_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_gnt     (w_i_gnt),
        .i_load_ok (~w_i_err),
        .i_err     (w_i_err),
        .i_rdata   (mem_data_out),
        .i_ready   (i_rsp_ready),
        .o_valid   (i_rsp_valid),
        .o_data    (i_rsp_data),
        .o_err     (i_rsp_err)
    );

    mem_arbiter_rsp u_d_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_gnt     (w_d_gnt),
        .i_load_ok (~d_req_we & ~w_d_err),
        .i_err     (w_d_err),
        .i_rdata   (mem_data_out),
        .i_ready   (d_rsp_ready),
        .o_valid   (d_rsp_valid),
        .o_data    (d_rsp_data),
        .o_err     (d_rsp_err)
    );
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM model, reference memory and per-port response
// scoreboards filled at grant time and drained by a negedge monitor.

module tb_mem_arbiter;
    localparam int SZ       = 4096;
    localparam int MAX_WAIT = 3;
    localparam int WORDS    = SZ / 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_err;
    logic [31:0] i_req_addr, i_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic        mem_w_en;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;

    logic [31:0] ram     [WORDS];
    logic [31:0] ref_mem [WORDS];
    bit          ram_init = 1'b0;
    int          cyc = 0;
    int          vecs = 0;
    int          errs = 0;
    rsp_t        iq[$];
    rsp_t        dq[$];

    mem_arbiter #(.SZ(SZ), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
        .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
        .d_rsp_err(d_rsp_err),
        .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int k);
        return (k == 0) ? 32'h01000093 : (32'hA5000000 ^ (32'(k) * 32'h00010203));
    endfunction

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a > 32'(SZ - 4));
    endfunction

    // RAM model: filled on the first edge (reset is held low then), written on mem_w_en.
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int k = 0; k < WORDS; k++) ram[k] <= init_val(k);
            ram_init <= 1'b1;
        end else if (mem_w_en && (mem_addr < 32'(SZ))) begin
            ram[mem_addr[11:2]] <= mem_data_in;
        end
    end
    assign mem_data_out = (mem_addr < 32'(SZ)) ? ram[mem_addr[11:2]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response monitor: latency, data/err against scoreboard head, stability under stall.
    always @(negedge clk) begin
        if (rst_n) begin
            if (iq.size() > 0 && iq[0].due == cyc) chk("i_rsp_latency", 32'(i_rsp_valid), 32'd1);
            if (i_rsp_valid) begin
                if (iq.size() == 0) chk("i_rsp_spurious", 32'(i_rsp_valid), 32'd0);
                else begin
                    chk("i_rsp_data", i_rsp_data, iq[0].data);
                    chk("i_rsp_err", 32'(i_rsp_err), 32'(iq[0].err));
                    if (i_rsp_ready) void'(iq.pop_front());
                end
            end
            if (dq.size() > 0 && dq[0].due == cyc) chk("d_rsp_latency", 32'(d_rsp_valid), 32'd1);
            if (d_rsp_valid) begin
                if (dq.size() == 0) chk("d_rsp_spurious", 32'(d_rsp_valid), 32'd0);
                else begin
                    chk("d_rsp_data", d_rsp_data, dq[0].data);
                    chk("d_rsp_err", 32'(d_rsp_err), 32'(dq[0].err));
                    if (d_rsp_ready) void'(dq.pop_front());
                end
            end
        end
    end

    task automatic set_i(input logic v, input logic [31:0] a);
        i_req_valid = v;
        i_req_addr  = a;
    endtask

    task automatic set_d(input logic v, input logic we, input logic [31:0] a, input logic [31:0] wd);
        d_req_valid = v;
        d_req_we    = we;
        d_req_addr  = a;
        d_req_wdata = wd;
    endtask

    // Checks one cycle's grant and memory drive, records the expected response, advances.
    task automatic expect_grant(input bit ei, input bit ed);
        rsp_t e;
        logic de, ie;
        @(negedge clk);
        de = addr_err(d_req_addr);
        ie = addr_err(i_req_addr);
        chk("i_req_ready", 32'(i_req_ready), 32'(ei));
        chk("d_req_ready", 32'(d_req_ready), 32'(ed));
        if (ed) begin
            chk("mem_addr_d", mem_addr, d_req_addr);
            chk("mem_w_en_d", 32'(mem_w_en), 32'(d_req_we && !de));
            chk("mem_data_in_d", mem_data_in, d_req_wdata);
            e.data = (!d_req_we && !de) ? ref_mem[d_req_addr[11:2]] : 32'h0;
            e.err  = de;
            e.due  = cyc + 1;
            dq.push_back(e);
            if (d_req_we && !de) ref_mem[d_req_addr[11:2]] = d_req_wdata;
        end else if (ei) begin
            chk("mem_addr_i", mem_addr, i_req_addr);
            chk("mem_w_en_i", 32'(mem_w_en), 32'd0);
            e.data = ie ? 32'h0 : ref_mem[i_req_addr[11:2]];
            e.err  = ie;
            e.due  = cyc + 1;
            iq.push_back(e);
        end else begin
            chk("mem_addr_idle", mem_addr, 32'h0);
            chk("mem_w_en_idle", 32'(mem_w_en), 32'd0);
            chk("mem_data_in_idle", mem_data_in, 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        for (int k = 0; k < WORDS; k++) ref_mem[k] = init_val(k);
        rst_n = 1'b0;
        i_rsp_ready = 1'b1;
        d_rsp_ready = 1'b1;
        set_i(1'b1, 32'h0);
        set_d(1'b1, 1'b1, 32'd16, 32'h12345678);
        #2;
        chk("rst_i_req_ready", 32'(i_req_ready), 32'd0);
        chk("rst_d_req_ready", 32'(d_req_ready), 32'd0);
        chk("rst_mem_w_en", 32'(mem_w_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_data_in", mem_data_in, 32'h0);
        chk("rst_i_rsp_valid", 32'(i_rsp_valid), 32'd0);
        chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
        chk("rst_i_rsp_data", i_rsp_data, 32'h0);
        chk("rst_d_rsp_data", d_rsp_data, 32'h0);
        chk("rst_d_rsp_err", 32'(d_rsp_err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        set_i(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // single fetch, then idle
        set_i(1'b1, 32'h0);                         expect_grant(1, 0);
        set_i(1'b0, 32'h0);                         expect_grant(0, 0);

        // store then load same word back to back
        set_d(1'b1, 1'b1, 32'd16, 32'h0000007B);    expect_grant(0, 1);
        set_d(1'b1, 1'b0, 32'd16, 32'h0);           expect_grant(0, 1);
        set_d(1'b0, 1'b0, 32'h0, 32'h0);            expect_grant(0, 0);

        // contention; dropping i_req_valid clears the starve count
        set_i(1'b1, 32'd4);
        set_d(1'b1, 1'b0, 32'd8, 32'h0);
        expect_grant(0, 1);
        expect_grant(0, 1);
        set_i(1'b0, 32'd4);                         expect_grant(0, 1);
        set_i(1'b1, 32'd4);
        expect_grant(0, 1);
        expect_grant(0, 1);
        expect_grant(0, 1);
        expect_grant(1, 0);
        expect_grant(0, 1);
        expect_grant(0, 1);
        set_i(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 32'h0, 32'h0);            expect_grant(0, 0);

        // error and boundary addresses
        set_d(1'b1, 1'b0, 32'h2, 32'h0);            expect_grant(0, 1);
        set_d(1'b1, 1'b0, 32'd4094, 32'h0);         expect_grant(0, 1);
        set_d(1'b1, 1'b1, 32'd4093, 32'hFFFFFFFF);  expect_grant(0, 1);
        set_d(1'b1, 1'b0, 32'd4092, 32'h0);         expect_grant(0, 1);
        set_d(1'b1, 1'b0, 32'd4096, 32'h0);         expect_grant(0, 1);
        set_d(1'b1, 1'b1, 32'd4092, 32'hDEADBEEF);  expect_grant(0, 1);
        set_d(1'b1, 1'b0, 32'd4092, 32'h0);         expect_grant(0, 1);
        set_d(1'b0, 1'b0, 32'h0, 32'h0);            expect_grant(0, 0);

        // data response stalled: fetch keeps being served, each fetch replacing the last
        d_rsp_ready = 1'b0;
        set_d(1'b1, 1'b0, 32'd20, 32'h0);
        set_i(1'b1, 32'd24);                        expect_grant(0, 1);
        for (int k = 0; k < 5; k++) begin
            set_i(1'b1, 32'(28 + 4 * k));           expect_grant(1, 0);
        end
        d_rsp_ready = 1'b1;
        set_i(1'b0, 32'h0);
        set_d(1'b0, 1'b0, 32'h0, 32'h0);            expect_grant(0, 0);

        // reset during a store grant
        set_d(1'b1, 1'b0, 32'd52, 32'h0);           expect_grant(0, 1);
        set_d(1'b1, 1'b1, 32'd48, 32'h55555555);
        #1;
        chk("pre_rst_d_req_ready", 32'(d_req_ready), 32'd1);
        chk("pre_rst_mem_w_en", 32'(mem_w_en), 32'd1);
        chk("pre_rst_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_w_en", 32'(mem_w_en), 32'd0);
        chk("midrst_d_req_ready", 32'(d_req_ready), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
        chk("midrst_d_rsp_data", d_rsp_data, 32'h0);
        chk("midrst_i_rsp_valid", 32'(i_rsp_valid), 32'd0);
        dq.delete();
        iq.delete();
        @(posedge clk);
        #1;
        set_d(1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        expect_grant(0, 0);
        set_d(1'b1, 1'b0, 32'd48, 32'h0);           expect_grant(0, 1);
        set_d(1'b0, 1'b0, 32'h0, 32'h0);            expect_grant(0, 0);
        expect_grant(0, 0);

        chk("i_queue_drained", 32'(iq.size()), 32'd0);
        chk("d_queue_drained", 32'(dq.size()), 32'd0);
        bad = 0;
        for (int k = 0; k < WORDS; k++) if (ram[k] !== ref_mem[k]) bad++;
        chk("ram_contents", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
